pipeline_hazard_unit: RTL and testbench

Parametrised hazard controller for the in-order MIPS pipeline: F, D, then DEPTH back-end slots (EX..WB).
- Keeps a scoreboard of in-flight register writes.
- Detects load-use hazards in decode and drives F/D stall, bubble and flush controls.
- Produces registered forwarding selects for the instruction entering EX.
- Keeps saturating stall/flush performance counters.
- Sits beside decode_stage; the datapath consumes its outputs.

---
 rtl/pipeline_hazard_unit.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - load-use hazard detection, F/D stall/flush control and EX forwarding selects
//
// Purpose: tracks in-flight register writes for the DEPTH back-end slots
// (slot 0 = EX .. slot DEPTH-1 = WB). It stalls decode on a load-use hazard,
// flushes F/D on a resolved branch/jump, and registers forwarding selects
// for the instruction entering EX. It also keeps saturating perf counters.
//
// Ports:
//   SYS_clk, SYS_reset       clock (state on falling edge), sync active-low reset
//   D_*                      decode-stage instruction fields
//   EX_flush                 taken branch/jump resolved in EX
//   perf_clear               synchronous counter clear
//   F_stall, D_stall         hold PC / hold IF/ID
//   D_bubble, D_flush        zero ID/EX / zero IF/ID
//   EX_fwd_a_sel/b_sel       registered operand sources for the EX instruction
//   sb_valid                 scoreboard valid bits (debug)
//   stall_cnt, flush_cnt     saturating performance counters

module pipeline_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_AVAIL = 2,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(DEPTH)
) (
    input  logic                  SYS_clk,
    input  logic                  SYS_reset,
    input  logic                  D_valid,
    input  logic [REG_ADDR_W-1:0] D_rs,
    input  logic [REG_ADDR_W-1:0] D_rt,
    input  logic                  D_rs_used,
    input  logic                  D_rt_used,
    input  logic                  D_RegWrite,
    input  logic [REG_ADDR_W-1:0] D_write_register,
    input  logic                  D_MemRead,
    input  logic                  EX_flush,
    input  logic                  perf_clear,
    output logic                  F_stall,
    output logic                  D_stall,
    output logic                  D_bubble,
    output logic                  D_flush,
    output logic [SEL_W-1:0]      EX_fwd_a_sel,
    output logic [SEL_W-1:0]      EX_fwd_b_sel,
    output logic [DEPTH-1:0]      sb_valid,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic [DEPTH-1:0]                 sb_valid_q, sb_valid_d;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] sb_dest_q,  sb_dest_d;
    logic [DEPTH-1:0]                 sb_load_q,  sb_load_d;
    logic [SEL_W-1:0]                 fwd_a_q, fwd_a_d;
    logic [SEL_W-1:0]                 fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]                 stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]                 flush_cnt_q, flush_cnt_d;

    logic             haz_a, haz_b;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic             load_use;
    logic             flush;
    logic             new_valid;

    // Walk oldest to youngest so the youngest matching slot overwrites
    // whatever an older slot decided.
    always_comb begin
        haz_a = 1'b0;
        haz_b = 1'b0;
        sel_a = '0;
        sel_b = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (D_rs_used && (D_rs != '0) && sb_valid_q[k] && (sb_dest_q[k] == D_rs)) begin
                haz_a = sb_load_q[k] && (k < LOAD_AVAIL - 1);
                sel_a = (k <= DEPTH - 2) ? SEL_W'(k + 1) : '0;
            end
            if (D_rt_used && (D_rt != '0) && sb_valid_q[k] && (sb_dest_q[k] == D_rt)) begin
                haz_b = sb_load_q[k] && (k < LOAD_AVAIL - 1);
                sel_b = (k <= DEPTH - 2) ? SEL_W'(k + 1) : '0;
            end
        end
    end

    // Flush wins over stall; everything is held quiet during reset.
    assign flush    = SYS_reset & EX_flush;
    assign load_use = SYS_reset & D_valid & ~EX_flush & (haz_a | haz_b);

    assign F_stall  = load_use;
    assign D_stall  = load_use;
    assign D_bubble = load_use | flush;
    assign D_flush  = flush;

    assign new_valid = ~D_bubble & D_valid & D_RegWrite & (D_write_register != '0);

    always_comb begin
        sb_valid_d = {sb_valid_q[DEPTH-2:0], new_valid};
        sb_dest_d  = {sb_dest_q[DEPTH-2:0], D_write_register};
        sb_load_d  = {sb_load_q[DEPTH-2:0], D_MemRead};

        fwd_a_d = D_bubble ? '0 : sel_a;
        fwd_b_d = D_bubble ? '0 : sel_b;

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (perf_clear) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (load_use && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
            if (flush && (flush_cnt_q != '1))    flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Falling edge, in step with the datapath stage registers.
    always_ff @(negedge SYS_clk) begin
        if (!SYS_reset) begin
            sb_valid_q  <= '0;
            sb_dest_q   <= '0;
            sb_load_q   <= '0;
            fwd_a_q     <= '0;
            fwd_b_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_valid_q  <= sb_valid_d;
            sb_dest_q   <= sb_dest_d;
            sb_load_q   <= sb_load_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign EX_fwd_a_sel = fwd_a_q;
    assign EX_fwd_b_sel = fwd_b_q;
    assign sb_valid     = sb_valid_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb/tb_pipeline_hazard_unit.sv - directed self-checking bench for pipeline_hazard_unit

module tb_pipeline_hazard_unit;

    logic       SYS_clk;
    logic       SYS_reset;
    logic       D_valid;
    logic [4:0] D_rs, D_rt, D_write_register;
    logic       D_rs_used, D_rt_used, D_RegWrite, D_MemRead;
    logic       EX_flush, perf_clear;
    logic       F_stall, D_stall, D_bubble, D_flush;
    logic [1:0] EX_fwd_a_sel, EX_fwd_b_sel;
    logic [2:0] sb_valid;
    logic [1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_hazard_unit #(
        .REG_ADDR_W(5),
        .DEPTH(3),
        .LOAD_AVAIL(2),
        .CNT_W(2)
    ) dut (
        .SYS_clk(SYS_clk),
        .SYS_reset(SYS_reset),
        .D_valid(D_valid),
        .D_rs(D_rs),
        .D_rt(D_rt),
        .D_rs_used(D_rs_used),
        .D_rt_used(D_rt_used),
        .D_RegWrite(D_RegWrite),
        .D_write_register(D_write_register),
        .D_MemRead(D_MemRead),
        .EX_flush(EX_flush),
        .perf_clear(perf_clear),
        .F_stall(F_stall),
        .D_stall(D_stall),
        .D_bubble(D_bubble),
        .D_flush(D_flush),
        .EX_fwd_a_sel(EX_fwd_a_sel),
        .EX_fwd_b_sel(EX_fwd_b_sel),
        .sb_valid(sb_valid),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    initial SYS_clk = 1'b1;
    always #5 SYS_clk = ~SYS_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Apply a decode instruction; called just after a falling edge.
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ru, input logic tu, input logic rw,
                         input logic [4:0] wd, input logic mr, input logic fl);
        D_valid = v; D_rs = rs; D_rt = rt; D_rs_used = ru; D_rt_used = tu;
        D_RegWrite = rw; D_write_register = wd; D_MemRead = mr; EX_flush = fl;
        #1;
    endtask

    task automatic tick;
        @(negedge SYS_clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check_eq(tag, {F_stall, D_stall, D_bubble, D_flush}, exp);
    endtask

    initial begin
        SYS_reset  = 1'b0;
        perf_clear = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();
        check_ctl("reset_ctl", 4'b0000);
        check_eq("reset_sb", sb_valid, 3'b000);
        check_eq("reset_sel", {EX_fwd_a_sel, EX_fwd_b_sel}, 4'h0);
        check_eq("reset_cnt", {stall_cnt, flush_cnt}, 4'h0);
        SYS_reset = 1'b1;
        nops(3);

        // 1: ALU forwarding at distance 1, 2, 3
        drive(1, 1, 2, 1, 1, 1, 8, 0, 0); tick();          // add r8,r1,r2
        drive(1, 8, 9, 1, 1, 1, 10, 0, 0);                  // sub r10,r8,r9
        check_ctl("t1_nostall", 4'b0000);
        tick();
        check_eq("t1_d1_a", EX_fwd_a_sel, 2'd1);
        check_eq("t1_d1_b", EX_fwd_b_sel, 2'd0);
        nops(3);
        drive(1, 1, 2, 1, 1, 1, 8, 0, 0); tick();
        nops(1);
        drive(1, 8, 9, 1, 1, 1, 10, 0, 0); tick();
        check_eq("t1_d2_a", EX_fwd_a_sel, 2'd2);
        nops(3);
        drive(1, 1, 2, 1, 1, 1, 8, 0, 0); tick();
        nops(2);
        drive(1, 8, 9, 1, 1, 1, 10, 0, 0); tick();
        check_eq("t1_d3_a", EX_fwd_a_sel, 2'd0);
        nops(3);

        // 2: load-use, one stall cycle
        drive(1, 1, 0, 1, 0, 1, 8, 1, 0); tick();          // lw r8,0(r1)
        check_eq("t2_sb_lw", sb_valid, 3'b001);
        drive(1, 8, 8, 1, 1, 1, 9, 0, 0);                   // add r9,r8,r8
        check_ctl("t2_stall", 4'b1110);
        tick();
        check_eq("t2_stall_cnt", stall_cnt, 2'd1);
        check_eq("t2_sb_bubble", sb_valid, 3'b010);
        check_eq("t2_sel_bubble", {EX_fwd_a_sel, EX_fwd_b_sel}, 4'h0);
        check_ctl("t2_released", 4'b0000);
        tick();
        check_eq("t2_sel_a", EX_fwd_a_sel, 2'd2);
        check_eq("t2_sel_b", EX_fwd_b_sel, 2'd2);
        check_eq("t2_sb_after", sb_valid, 3'b101);
        check_eq("t2_stall_cnt_hold", stall_cnt, 2'd1);
        nops(3);

        // 3: younger ALU write shadows older load
        drive(1, 1, 0, 1, 0, 1, 8, 1, 0); tick();          // lw r8
        drive(1, 1, 0, 1, 0, 1, 8, 0, 0);                   // addi r8,r1,4
        check_ctl("t3_addi", 4'b0000);
        tick();
        drive(1, 8, 3, 1, 1, 1, 2, 0, 0);                   // add r2,r8,r3
        check_ctl("t3_add", 4'b0000);
        tick();
        check_eq("t3_sel_a", EX_fwd_a_sel, 2'd1);
        check_eq("t3_sel_b", EX_fwd_b_sel, 2'd0);
        nops(3);

        // 4: r0 never matches; unused source never matches
        drive(1, 1, 0, 1, 0, 1, 0, 1, 0); tick();          // lw r0
        check_eq("t4_sb_r0", sb_valid, 3'b000);
        drive(1, 0, 0, 1, 1, 1, 5, 0, 0);
        check_ctl("t4_r0", 4'b0000);
        tick();
        check_eq("t4_r0_sel", {EX_fwd_a_sel, EX_fwd_b_sel}, 4'h0);
        nops(3);
        drive(1, 1, 0, 1, 0, 1, 8, 1, 0); tick();          // lw r8
        drive(1, 1, 8, 1, 0, 1, 6, 0, 0);                   // rt=8 not read
        check_ctl("t4_unused", 4'b0000);
        tick();
        check_eq("t4_unused_sel", EX_fwd_b_sel, 2'd0);
        nops(3);

        // 5: flush beats a same-cycle load-use
        drive(1, 1, 0, 1, 0, 1, 8, 1, 0); tick();
        drive(1, 8, 8, 1, 1, 1, 9, 0, 1);
        check_ctl("t5_flush", 4'b0011);
        tick();
        check_eq("t5_flush_cnt", flush_cnt, 2'd1);
        check_eq("t5_stall_cnt", stall_cnt, 2'd1);
        check_eq("t5_sb", sb_valid, 3'b010);
        nops(3);

        // 6: clear, saturation, clear-vs-increment, mid-stream reset
        perf_clear = 1'b1;
        nops(1);
        perf_clear = 1'b0;
        check_eq("t6_clear", {stall_cnt, flush_cnt}, 4'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 1, 0, 1, 8, 1, 0); tick();
            drive(1, 8, 8, 1, 1, 1, 9, 0, 0); tick();
        end
        check_eq("t6_sat", stall_cnt, 2'd3);
        nops(3);
        drive(1, 1, 0, 1, 0, 1, 8, 1, 0); tick();
        drive(1, 8, 8, 1, 1, 1, 9, 0, 0);
        perf_clear = 1'b1;
        check_ctl("t6_clr_stall", 4'b1110);
        tick();
        perf_clear = 1'b0;
        check_eq("t6_clr_beats_inc", stall_cnt, 2'd0);
        nops(3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();          // flush cycle
        drive(1, 1, 2, 1, 1, 1, 8, 0, 0); tick();          // add r8
        drive(1, 8, 0, 1, 0, 1, 9, 1, 0); tick();          // lw r9,0(r8)
        check_eq("t6_pre_sel", EX_fwd_a_sel, 2'd1);
        check_eq("t6_pre_cnt", flush_cnt, 2'd1);
        check_eq("t6_pre_sb", sb_valid, 3'b011);
        drive(1, 9, 0, 1, 0, 1, 4, 0, 1);
        SYS_reset = 1'b0;
        #1;
        check_ctl("t6_rst_ctl", 4'b0000);
        tick();
        check_eq("t6_rst_sb", sb_valid, 3'b000);
        check_eq("t6_rst_sel", {EX_fwd_a_sel, EX_fwd_b_sel}, 4'h0);
        check_eq("t6_rst_cnt", {stall_cnt, flush_cnt}, 4'h0);
        SYS_reset = 1'b1;
        drive(1, 1, 2, 1, 1, 1, 8, 0, 0); tick();
        check_eq("t6_post_sb", sb_valid, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
